// File: rtl/mips_muldiv_pkg.sv
// Shared types and constants for the MIPS iterative multiply/divide unit.
package mips_muldiv_pkg;

    localparam int unsigned MULDIV_WIDTH   = 32;
    localparam int unsigned MULDIV_LATENCY = MULDIV_WIDTH + 1;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } muldiv_state_t;

endpackage

// File: rtl/mips_muldiv_if.sv
// Core-side bundle for the multiply/divide unit: op launch, MTHI/MTLO, HI/LO readback.
interface mips_muldiv_if
    import mips_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
);
    logic             start;
    muldiv_op_t       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             hi_write;
    logic             lo_write;
    logic [WIDTH-1:0] write_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, hi_write, lo_write, write_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, hi_write, lo_write, write_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO; one bit per cycle on magnitudes,
// sign fix-up in a final cycle.
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
) (
    input logic           clk,
    input logic           reset,
    mips_muldiv_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    muldiv_state_t      state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    muldiv_op_t         op_q, op_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               is_signed, is_div, sa, sb, ge;
    logic [WIDTH-1:0]   mag_a, mag_b, diff;
    logic [WIDTH:0]     sum, rem_wide;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
        mcand_d    = mcand_q;
        acc_d      = acc_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        is_div     = bus.op[1];
        is_signed  = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        sa         = is_signed & bus.rs_data[WIDTH-1];
        sb         = is_signed & bus.rt_data[WIDTH-1];
        mag_a      = sa ? -bus.rs_data : bus.rs_data;
        mag_b      = sb ? -bus.rt_data : bus.rt_data;
        sum        = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
        // Remainder shifted left with the next dividend bit brought in.
        rem_wide   = acc_q[2*WIDTH-1:WIDTH-1];
        ge         = rem_wide >= {1'b0, mcand_q};
        diff       = rem_wide[WIDTH-1:0] - mcand_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.hi_write) hi_d = bus.write_data;
                if (bus.lo_write) lo_d = bus.write_data;
                if (bus.start) begin
                    op_d       = bus.op;
                    neg_d      = sa ^ sb;
                    rem_neg_d  = sa;
                    div_zero_d = is_div && (bus.rt_data == '0);
                    // Low half holds the multiplier, or the dividend that becomes the quotient.
                    acc_d      = {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
                    mcand_d    = is_div ? mag_b : mag_a;
                    cnt_d      = CW'(WIDTH - 1);
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (op_q[1]) begin
                    acc_d = ge ? {diff, acc_q[WIDTH-2:0], 1'b1}
                               : {acc_q[2*WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {sum, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == '0) state_d = S_FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_FIX: begin
                if (!op_q[1]) begin
                    {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
                end else if (!div_zero_q) begin
                    lo_d = neg_q     ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
                    hi_d = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= OP_MULT;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            mcand_q    <= '0;
            acc_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
            mcand_q    <= mcand_d;
            acc_q      <= acc_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: stimulus queues expected HI/LO, a monitor checks on done.
module tb_mips_muldiv_unit;
    import mips_muldiv_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   busy_cnt = 0;
    exp_t sb_q[$];

    mips_muldiv_if #(.WIDTH(32)) bus ();

    mips_muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: counts busy cycles and pops one expectation per done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_cnt = 0;
            end else begin
                if (bus.busy) busy_cnt++;
                if (bus.done) begin
                    check("busy_cycles", 32'(busy_cnt), 32'(MULDIV_LATENCY));
                    busy_cnt = 0;
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL spurious_done: got done=1 expected no pending op");
                    end else begin
                        e = sb_q.pop_front();
                        check({e.name, "_hi"}, bus.hi, e.hi);
                        check({e.name, "_lo"}, bus.lo, e.lo);
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((bus.busy || bus.done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("done_timeout", 32'(bus.done), 32'd1);
        @(negedge clk);
    endtask

    task automatic issue(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] eh, input logic [31:0] el,
                         input string name);
        exp_t e;
        wait_idle();
        bus.op      = op;
        bus.rs_data = a;
        bus.rt_data = b;
        bus.start   = 1'b1;
        if (push) begin
            e.hi = eh;
            e.lo = el;
            e.name = name;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.hi_write = 1'b0;
        bus.lo_write = 1'b0;
        bus.rs_data = $urandom;
        bus.rt_data = $urandom;
        @(negedge clk);
    endtask

    initial begin
        int n;
        bus.start      = 1'b0;
        bus.op         = OP_MULTU;
        bus.rs_data    = '0;
        bus.rt_data    = '0;
        bus.hi_write   = 1'b0;
        bus.lo_write   = 1'b0;
        bus.write_data = '0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        issue(OP_MULT,  32'hFFFF_FFFD, 32'd7,         1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg");
        issue(OP_DIV,   32'hFFFF_FFF9, 32'd2,         1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
        issue(OP_DIVU,  32'd100,       32'd7,         1, 32'd2,         32'd14,        "divu_100_7");
        issue(OP_DIV,   32'd7,         32'hFFFF_FFFE, 1, 32'd1,         32'hFFFF_FFFD, "div_negdiv");
        issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0,         32'h8000_0000, "div_ovf");
        issue(OP_MULTU, 32'd0,         32'hDEAD_BEEF, 1, 32'd0,         32'd0,         "multu_zero");

        // MTHI/MTLO together in IDLE, then divide by zero must leave them.
        wait_idle();
        bus.hi_write   = 1'b1;
        bus.lo_write   = 1'b1;
        bus.write_data = 32'h1234;
        @(posedge clk);
        #1;
        bus.lo_write   = 1'b0;
        bus.write_data = 32'h5678;
        check("mthi", bus.hi, 32'h1234);
        check("mtlo_both", bus.lo, 32'h1234);
        bus.hi_write   = 1'b0;
        bus.lo_write   = 1'b1;
        @(posedge clk);
        #1;
        bus.lo_write   = 1'b0;
        check("mtlo", bus.lo, 32'h5678);
        issue(OP_DIVU, 32'd5, 32'd0, 1, 32'h1234, 32'h5678, "divu_by0");
        wait_done();

        // Mid-run start and MTLO are ignored.
        issue(OP_MULTU, 32'd3, 32'd4, 1, 32'd0, 32'd12, "multu_ignore");
        repeat (5) @(negedge clk);
        bus.start      = 1'b1;
        bus.op         = OP_DIVU;
        bus.rs_data    = 32'd99;
        bus.rt_data    = 32'd3;
        bus.lo_write   = 1'b1;
        bus.hi_write   = 1'b1;
        bus.write_data = 32'hDEAD;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.lo_write = 1'b0;
        bus.hi_write = 1'b0;
        check("busy_mtlo_lo", bus.lo, 32'h5678);
        wait_done();

        // MTHI in the launch cycle lands now, then the result overwrites it.
        wait_idle();
        bus.hi_write   = 1'b1;
        bus.write_data = 32'hAAAA;
        issue(OP_MULTU, 32'd2, 32'd3, 1, 32'd0, 32'd6, "start_mthi");
        check("start_mthi_now", bus.hi, 32'hAAAA);
        wait_done();

        // Reset mid-operation clears everything immediately.
        issue(OP_MULT, 32'hFFFF_FFF0, 32'd5, 0, 32'd0, 32'd0, "aborted");
        repeat (8) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "post_reset");
        issue(OP_DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFF, 32'd3, "div_bothneg");

        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) check("drain_timeout", 32'(sb_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
